// File: rtl/ob_cmd_scheduler_pkg.sv
// rtl/ob_cmd_scheduler_pkg.sv - shared encodings for the order-book command scheduler
package ob_cmd_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ORD_ISSUE  = 3'd1,
    ST_DUMP_REQ   = 3'd2,
    ST_DUMP_START = 3'd3,
    ST_DUMP_RUN   = 3'd4,
    ST_DUMP_DONE  = 3'd5
  } sched_state_e;

  localparam int DEST_UDP  = 0;
  localparam int DEST_UART = 1;

  localparam logic [7:0] UART_CMD_ARM  = 8'hFE;
  localparam logic [7:0] UART_CMD_DUMP = 8'h00;

endpackage

// File: rtl/ob_cmd_scheduler_if.sv
// rtl/ob_cmd_scheduler_if.sv - order, dump-request and engine command signals of the scheduler
interface ob_cmd_scheduler_if #(
  parameter int ORDER_W = 32,
  parameter int CNT_W   = 16
);
  logic [ORDER_W-1:0] ord_tdata;
  logic               ord_tvalid;
  logic               ord_tready;
  logic               udp_dump_req;
  logic [7:0]         uart_rx_data;
  logic               uart_rx_valid;
  logic               ob_cmd_valid;
  logic               ob_cmd_is_dump;
  logic [ORDER_W-1:0] ob_cmd_data;
  logic               ob_cmd_ready;
  logic               engine_busy;
  logic               dump_sink_idle;
  logic [1:0]         dump_dest;
  logic               dump_active;
  logic               dump_timeout;
  logic [CNT_W-1:0]   stat_orders;
  logic [CNT_W-1:0]   stat_dumps;
  logic [2:0]         sched_state;

  modport slave (
    input  ord_tdata, ord_tvalid, udp_dump_req, uart_rx_data, uart_rx_valid,
           ob_cmd_ready, engine_busy, dump_sink_idle,
    output ord_tready, ob_cmd_valid, ob_cmd_is_dump, ob_cmd_data, dump_dest,
           dump_active, dump_timeout, stat_orders, stat_dumps, sched_state
  );

  modport master (
    output ord_tdata, ord_tvalid, udp_dump_req, uart_rx_data, uart_rx_valid,
           ob_cmd_ready, engine_busy, dump_sink_idle,
    input  ord_tready, ob_cmd_valid, ob_cmd_is_dump, ob_cmd_data, dump_dest,
           dump_active, dump_timeout, stat_orders, stat_dumps, sched_state
  );
endinterface

// File: rtl/ob_uart_cmd_parser.sv
// rtl/ob_uart_cmd_parser.sv - turns the UART byte sequence FE 00 into a one-cycle dump pulse
module ob_uart_cmd_parser
  import ob_cmd_scheduler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       dump_pulse_o
);

  logic armed_q, armed_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) armed_q <= 1'b0;
    else          armed_q <= armed_d;
  end

  // A repeated FE keeps the parser armed so FE FE 00 still fires.
  always_comb begin
    armed_d      = armed_q;
    dump_pulse_o = 1'b0;
    if (rx_valid_i) begin
      if (rx_data_i == UART_CMD_ARM) begin
        armed_d = 1'b1;
      end else begin
        armed_d      = 1'b0;
        dump_pulse_o = armed_q && (rx_data_i == UART_CMD_DUMP);
      end
    end
  end

endmodule

// File: rtl/ob_cmd_scheduler.sv
// rtl/ob_cmd_scheduler.sv - merges market orders and dump requests into the order-book command stream
module ob_cmd_scheduler
  import ob_cmd_scheduler_pkg::*;
#(
  parameter int ORDER_W       = 32,
  parameter int START_TIMEOUT = 64,
  parameter int DUMP_TIMEOUT  = 1_000_000,
  parameter int CNT_W         = 16
) (
  input  logic              clk_engine,
  input  logic              rst_engine_n,
  ob_cmd_scheduler_if.slave bus
);

  localparam int TMR_W = $clog2(DUMP_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] START_LIM = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RUN_LIM   = TMR_W'(DUMP_TIMEOUT - 1);

  sched_state_e       state_q, state_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         dest_q, dest_d;
  logic               dump_last_q, dump_last_d;
  logic [ORDER_W-1:0] word_q, word_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   ord_cnt_q, ord_cnt_d;
  logic [CNT_W-1:0]   dmp_cnt_q, dmp_cnt_d;
  logic               uart_dump;
  logic               run_done;

  ob_uart_cmd_parser u_parser (
    .clk_i        (clk_engine),
    .rst_n_i      (rst_engine_n),
    .rx_data_i    (bus.uart_rx_data),
    .rx_valid_i   (bus.uart_rx_valid),
    .dump_pulse_o (uart_dump)
  );

  assign run_done = !bus.engine_busy && bus.dump_sink_idle;

  always_ff @(posedge clk_engine or negedge rst_engine_n) begin
    if (!rst_engine_n) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  // A waiting dump yields to a waiting order only right after another dump.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != 2'b00 && (!dump_last_q || !bus.ord_tvalid)) state_d = ST_DUMP_REQ;
        else if (bus.ord_tvalid)                                   state_d = ST_ORD_ISSUE;
      end
      ST_ORD_ISSUE:  if (bus.ob_cmd_ready) state_d = ST_IDLE;
      ST_DUMP_REQ:   if (bus.ob_cmd_ready) state_d = ST_DUMP_START;
      ST_DUMP_START: begin
        if (bus.engine_busy)        state_d = ST_DUMP_RUN;
        else if (tmr_q == START_LIM) state_d = ST_DUMP_DONE;
      end
      ST_DUMP_RUN:   if (run_done || tmr_q == RUN_LIM) state_d = ST_DUMP_DONE;
      ST_DUMP_DONE:  state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ord_tready     = rst_engine_n && (state_q == ST_IDLE) && (state_d == ST_ORD_ISSUE);
    bus.ob_cmd_valid   = (state_q == ST_ORD_ISSUE) || (state_q == ST_DUMP_REQ);
    bus.ob_cmd_is_dump = (state_q == ST_DUMP_REQ);
    bus.ob_cmd_data    = (state_q == ST_ORD_ISSUE) ? word_q : '0;
    bus.dump_active    = (state_q == ST_DUMP_REQ) || (state_q == ST_DUMP_START) ||
                         (state_q == ST_DUMP_RUN);
    bus.dump_dest      = dest_q;
    bus.dump_timeout   = timeout_q;
    bus.stat_orders    = ord_cnt_q;
    bus.stat_dumps     = dmp_cnt_q;
    bus.sched_state    = state_q;
  end

  always_comb begin
    pend_d      = pend_q;
    dest_d      = dest_q;
    dump_last_d = dump_last_q;
    word_d      = word_q;
    ord_cnt_d   = ord_cnt_q;
    dmp_cnt_d   = dmp_cnt_q;
    tmr_d       = (state_d != state_q) ? '0 : tmr_q + 1'b1;
    timeout_d   = (state_q == ST_DUMP_START && !bus.engine_busy && tmr_q == START_LIM) ||
                  (state_q == ST_DUMP_RUN && !run_done && tmr_q == RUN_LIM);

    if (state_q == ST_IDLE && state_d == ST_ORD_ISSUE) word_d = bus.ord_tdata;
    if (state_q == ST_ORD_ISSUE && bus.ob_cmd_ready) begin
      ord_cnt_d   = ord_cnt_q + 1'b1;
      dump_last_d = 1'b0;
    end
    if (state_q == ST_IDLE && state_d == ST_DUMP_REQ) begin
      dest_d = pend_q;
      pend_d = 2'b00;
    end
    if (state_q != ST_DUMP_DONE && state_d == ST_DUMP_DONE) begin
      dmp_cnt_d   = dmp_cnt_q + 1'b1;
      dest_d      = 2'b00;
      dump_last_d = 1'b1;
    end
    // New requests land after the entry clear so a same-cycle request is never lost.
    if (bus.udp_dump_req) pend_d[DEST_UDP]  = 1'b1;
    if (uart_dump)        pend_d[DEST_UART] = 1'b1;
  end

  always_ff @(posedge clk_engine or negedge rst_engine_n) begin
    if (!rst_engine_n) begin
      pend_q      <= 2'b00;
      dest_q      <= 2'b00;
      dump_last_q <= 1'b0;
      word_q      <= '0;
      tmr_q       <= '0;
      timeout_q   <= 1'b0;
      ord_cnt_q   <= '0;
      dmp_cnt_q   <= '0;
    end else begin
      pend_q      <= pend_d;
      dest_q      <= dest_d;
      dump_last_q <= dump_last_d;
      word_q      <= word_d;
      tmr_q       <= tmr_d;
      timeout_q   <= timeout_d;
      ord_cnt_q   <= ord_cnt_d;
      dmp_cnt_q   <= dmp_cnt_d;
    end
  end

endmodule

// File: tb/tb_ob_cmd_scheduler.sv
// tb/tb_ob_cmd_scheduler.sv - scoreboard bench for the order-book command scheduler
module tb_ob_cmd_scheduler;
  import ob_cmd_scheduler_pkg::*;

  localparam int START_TO = 64;

  typedef struct {
    bit          is_dump;
    logic [31:0] data;
    logic [1:0]  dest;
  } cmd_t;

  logic clk;
  logic rst_n;

  ob_cmd_scheduler_if #(.ORDER_W(32), .CNT_W(16)) bus ();

  ob_cmd_scheduler #(
    .ORDER_W       (32),
    .START_TIMEOUT (START_TO),
    .DUMP_TIMEOUT  (1_000_000),
    .CNT_W         (16)
  ) dut (
    .clk_engine   (clk),
    .rst_engine_n (rst_n),
    .bus          (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  cmd_t        exp_q[$];
  logic [31:0] ord_fifo[$];
  cmd_t        mon_e;
  bit          rdy_rand = 0;
  bit          stuck = 0;
  bit          dump_go = 0;
  bit          resp_busy = 0;
  int          busy_len = 50;
  logic [1:0]  dest_now = 2'b00;
  int          acc_cyc = 0;
  int          exp_dumps = 0;
  int          exp_orders = 0;
  int          cmd_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Order source: presents the head of the queue, pops it on handshake.
  always @(negedge clk) begin
    bus.ord_tvalid = (ord_fifo.size() > 0);
    bus.ord_tdata  = (ord_fifo.size() > 0) ? ord_fifo[0] : 32'd0;
    #1;
    if (bus.ord_tvalid && bus.ord_tready) void'(ord_fifo.pop_front());
  end

  // Engine-side ready driver and scoreboard monitor.
  always @(negedge clk) begin
    bus.ob_cmd_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (rst_n === 1'b1) begin
      if (bus.ob_cmd_valid && bus.ob_cmd_ready) begin
        cmd_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cmd: got is_dump=%0d data=%0h, required no command",
                   bus.ob_cmd_is_dump, bus.ob_cmd_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd_is_dump", bus.ob_cmd_is_dump, mon_e.is_dump);
          chk("cmd_data", bus.ob_cmd_data, mon_e.data);
          if (mon_e.is_dump) chk("cmd_dest", bus.dump_dest, mon_e.dest);
        end
        if (bus.ob_cmd_is_dump) begin
          dest_now  = mon_e.dest;
          acc_cyc   = cyc;
          dump_go   = 1'b1;
          resp_busy = 1'b1;
        end
      end
      if (bus.sched_state != 3'(ST_IDLE)) chk("ord_tready_outside_idle", bus.ord_tready, 0);
    end
  end

  task automatic run_normal();
    bit ab = 0;
    @(negedge clk);
    bus.engine_busy    = 1'b1;
    bus.dump_sink_idle = 1'b0;
    for (int i = 0; i < busy_len; i++) begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        ab = 1;
        break;
      end
      chk("dump_dest_held", bus.dump_dest, dest_now);
      chk("dump_active_run", bus.dump_active, 1);
    end
    if (ab) begin
      bus.engine_busy    = 1'b0;
      bus.dump_sink_idle = 1'b1;
      exp_dumps          = 0;
      return;
    end
    @(negedge clk);
    bus.engine_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("run_waits_for_sink", bus.sched_state, 3'(ST_DUMP_RUN));
    @(negedge clk);
    bus.dump_sink_idle = 1'b1;
    #1;
    chk("stat_dumps_before_done", bus.stat_dumps, 64'(exp_dumps));
    @(negedge clk);
    #1;
    exp_dumps++;
    chk("stat_dumps_after_done", bus.stat_dumps, 64'(exp_dumps));
    chk("state_done", bus.sched_state, 3'(ST_DUMP_DONE));
    chk("dest_zero_done", bus.dump_dest, 0);
    chk("dump_active_done", bus.dump_active, 0);
  endtask

  task automatic run_stuck();
    int t = -1;
    for (int i = 0; i < START_TO + 20; i++) begin
      @(negedge clk);
      #1;
      if (bus.dump_timeout) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout_pulse: got no dump_timeout, required one within %0d cycles", START_TO + 20);
    end else begin
      exp_dumps++;
      chk("timeout_latency", 64'(t - acc_cyc), 64'(START_TO + 1));
      chk("stat_dumps_timeout", bus.stat_dumps, 64'(exp_dumps));
      @(negedge clk);
      #1;
      chk("timeout_pulse_width", bus.dump_timeout, 0);
      chk("idle_after_timeout", bus.sched_state, 3'(ST_IDLE));
      chk("dest_after_timeout", bus.dump_dest, 0);
    end
  endtask

  initial begin
    bus.engine_busy    = 1'b0;
    bus.dump_sink_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (dump_go) begin
        dump_go = 1'b0;
        if (stuck) run_stuck();
        else       run_normal();
        resp_busy = 1'b0;
      end
    end
  end

  function automatic logic [31:0] mk_order(input int price, input bit is_buy, input int qty);
    return {16'(price), is_buy, 1'b0, 14'(qty)};
  endfunction

  task automatic push_order(input logic [31:0] w);
    ord_fifo.push_back(w);
    exp_q.push_back('{1'b0, w, 2'b00});
    exp_orders++;
  endtask

  task automatic push_dump(input logic [1:0] dest);
    exp_q.push_back('{1'b1, 32'd0, dest});
  endtask

  task automatic pulse_udp();
    bus.udp_dump_req = 1'b1;
    @(negedge clk);
    bus.udp_dump_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_udp);
    bus.uart_rx_data  = b;
    bus.uart_rx_valid = 1'b1;
    bus.udp_dump_req  = with_udp;
    @(negedge clk);
    bus.uart_rx_valid = 1'b0;
    bus.udp_dump_req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && ord_fifo.size() == 0 && !resp_busy &&
          bus.sched_state == 3'(ST_IDLE)) break;
      n++;
      if (n >= budget) begin
        tests++;
        fails++;
        $display("FAIL wait_done: got %0d commands outstanding after %0d cycles, required 0",
                 exp_q.size(), n);
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (!(bus.dump_active && bus.engine_busy)) begin
      @(negedge clk);
      #2;
      n++;
      if (n >= budget) begin
        tests++;
        fails++;
        $display("FAIL wait_run: got no running dump after %0d cycles, required one", n);
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int seen0;
    rst_n             = 1'b0;
    bus.udp_dump_req  = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_valid = 1'b0;
    #12;
    chk("rst_ob_cmd_valid", bus.ob_cmd_valid, 0);
    chk("rst_ord_tready", bus.ord_tready, 0);
    chk("rst_dump_dest", bus.dump_dest, 0);
    chk("rst_dump_active", bus.dump_active, 0);
    chk("rst_stat_orders", bus.stat_orders, 0);
    chk("rst_sched_state", bus.sched_state, 3'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_order(mk_order(105, 1'b0, 10));
    push_order(mk_order(90, 1'b1, 20));
    wait_done(500);
    chk("s1_stat_orders", bus.stat_orders, 64'(exp_orders));
    chk("s1_stat_dumps", bus.stat_dumps, 0);

    push_dump(2'b01);
    pulse_udp();
    wait_done(500);
    chk("s2_stat_dumps", bus.stat_dumps, 64'(exp_dumps));

    push_dump(2'b11);
    send_byte(UART_CMD_ARM, 1'b0);
    send_byte(UART_CMD_ARM, 1'b0);
    send_byte(UART_CMD_DUMP, 1'b1);
    wait_done(500);
    chk("s3_stat_dumps", bus.stat_dumps, 64'(exp_dumps));
    seen0 = cmd_seen;
    send_byte(UART_CMD_ARM, 1'b0);
    send_byte(8'h37, 1'b0);
    send_byte(UART_CMD_DUMP, 1'b0);
    repeat (30) @(negedge clk);
    chk("s3_no_dump_cmds", 64'(cmd_seen - seen0), 0);
    chk("s3_stat_dumps_unchanged", bus.stat_dumps, 64'(exp_dumps));

    push_dump(2'b01);
    pulse_udp();
    wait_run(100);
    ord_fifo.push_back(mk_order(106, 1'b0, 5));
    ord_fifo.push_back(mk_order(89, 1'b1, 7));
    exp_q.push_back('{1'b0, mk_order(106, 1'b0, 5), 2'b00});
    exp_q.push_back('{1'b1, 32'd0, 2'b01});
    exp_q.push_back('{1'b0, mk_order(89, 1'b1, 7), 2'b00});
    exp_orders += 2;
    pulse_udp();
    wait_done(1000);
    chk("s4_stat_orders", bus.stat_orders, 64'(exp_orders));
    chk("s4_stat_dumps", bus.stat_dumps, 64'(exp_dumps));

    stuck = 1'b1;
    push_dump(2'b01);
    pulse_udp();
    wait_done(500);
    stuck = 1'b0;
    chk("s5_stat_dumps", bus.stat_dumps, 64'(exp_dumps));

    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_order(mk_order($urandom_range(1, 1000), 1'($urandom_range(0, 1)),
                          $urandom_range(1, 16383)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done(3000);
    rdy_rand = 1'b0;
    chk("s6_stat_orders", bus.stat_orders, 64'(exp_orders));

    busy_len = 300;
    push_dump(2'b10);
    send_byte(UART_CMD_ARM, 1'b0);
    send_byte(UART_CMD_DUMP, 1'b0);
    wait_run(100);
    repeat (10) @(negedge clk);
    pulse_udp();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s7_ob_cmd_valid", bus.ob_cmd_valid, 0);
    chk("s7_dump_active", bus.dump_active, 0);
    chk("s7_dump_dest", bus.dump_dest, 0);
    chk("s7_stat_orders", bus.stat_orders, 0);
    chk("s7_stat_dumps", bus.stat_dumps, 0);
    chk("s7_sched_state", bus.sched_state, 3'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n      = 1'b1;
    exp_orders = 0;
    busy_len   = 50;
    seen0      = cmd_seen;
    repeat (40) @(negedge clk);
    #2;
    chk("s7_no_replay", 64'(cmd_seen - seen0), 0);
    chk("s7_idle_after_release", bus.sched_state, 3'(ST_IDLE));
    chk("s7_stat_dumps_after", bus.stat_dumps, 64'(exp_dumps));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
